// File: rtl/lr_shift_arbiter.sv
// Two-requester round-robin arbiter in front of a shared zero-fill left/right shifter
// with one registered result stage. Define LR_SHIFT_ARB_STATS_EN to add per-requester grant counters.

module lr_shift_unit #(
  parameter int width = 8,
  parameter int SW    = 3
) (
  input  logic [width-1:0] bits,
  input  logic [SW-1:0]    shift,
  input  logic             dir,
  output logic [width-1:0] res
);
  // Amounts >= width fall out naturally as zero for non-power-of-2 widths.
  always_comb res = dir ? (bits >> shift) : (bits << shift);
endmodule

module lr_shift_arbiter #(
  parameter  int width = 8,
  localparam int SW    = (width > 1) ? $clog2(width) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [width-1:0] r0_bits,
  input  logic [SW-1:0]    r0_shift,
  input  logic             r0_dir,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [width-1:0] r1_bits,
  input  logic [SW-1:0]    r1_shift,
  input  logic             r1_dir,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_bits,
  output logic             o_src
`ifdef LR_SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]      g0_cnt,
  output logic [15:0]      g1_cnt
`endif
);

  typedef struct packed {
    logic [width-1:0] bits;
    logic [SW-1:0]    shift;
    logic             dir;
  } req_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             last;
  logic             accept, gnt_vld, gnt, xfer;
  req_t             sel;
  logic [width-1:0] res;

  assign accept = (state == EMPTY) | o_ready;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    gnt_vld = r0_valid | r1_valid;
    gnt     = 1'b0;
    if (r0_valid & r1_valid) gnt = ~last;
    else if (r1_valid)       gnt = 1'b1;
  end

  assign r0_ready = accept & gnt_vld & ~gnt;
  assign r1_ready = accept & gnt_vld &  gnt;
  assign xfer     = accept & gnt_vld & ~rst;

  always_comb begin
    sel = gnt ? '{bits: r1_bits, shift: r1_shift, dir: r1_dir}
              : '{bits: r0_bits, shift: r0_shift, dir: r0_dir};
  end

  lr_shift_unit #(.width(width), .SW(SW)) u_shift (
    .bits  (sel.bits),
    .shift (sel.shift),
    .dir   (sel.dir),
    .res   (res)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (xfer) state_nxt = FULL;
      FULL:  if (!xfer && o_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      o_bits <= '0;
      o_src  <= 1'b0;
      last   <= 1'b1;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        o_bits <= res;
        o_src  <= gnt;
        last   <= gnt;
      end
    end
  end

  assign o_valid = (state == FULL);

`ifdef LR_SHIFT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      g0_cnt <= '0;
      g1_cnt <= '0;
    end else if (xfer) begin
      if (!gnt && g0_cnt != 16'hFFFF) g0_cnt <= g0_cnt + 16'd1;
      if ( gnt && g1_cnt != 16'hFFFF) g1_cnt <= g1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lr_shift_arbiter.sv
// Scoreboard bench for lr_shift_arbiter (width=8): a behavioural model tracks grant order
// and the result register every cycle; shifted words queue at handshake and pop on delivery.

module tb_lr_shift_arbiter;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_valid = 0, r1_valid = 0, r0_dir = 0, r1_dir = 0, o_ready = 0;
  logic [W-1:0]  r0_bits = 0, r1_bits = 0;
  logic [SW-1:0] r0_shift = 0, r1_shift = 0;
  logic          r0_ready, r1_ready, o_valid, o_src;
  logic [W-1:0]  o_bits;
`ifdef LR_SHIFT_ARB_STATS_EN
  logic [15:0]   g0_cnt, g1_cnt;
`endif

  lr_shift_arbiter #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_bits(r0_bits), .r0_shift(r0_shift), .r0_dir(r0_dir),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_bits(r1_bits), .r1_shift(r1_shift), .r1_dir(r1_dir),
    .o_valid(o_valid), .o_ready(o_ready), .o_bits(o_bits), .o_src(o_src)
`ifdef LR_SHIFT_ARB_STATS_EN
    , .g0_cnt(g0_cnt), .g1_cnt(g1_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic       mon_en = 1'b0;
  logic       m_valid = 1'b0, m_src = 1'b0, m_last = 1'b1;
  logic [W-1:0] m_bits = '0;
  logic [W:0] sb[$];
  int         m_g0 = 0, m_g1 = 0;

  always @(negedge clk) begin
    logic acc, gv, g, xf, d;
    logic [W-1:0] b, res;
    logic [SW-1:0] s;
    logic [W:0] e;
    if (mon_en) begin
      chk("o_valid", o_valid, m_valid);
      chk("o_bits", o_bits, m_bits);
      chk("o_src", o_src, m_src);
      acc = !m_valid || o_ready;
      gv  = r0_valid || r1_valid;
      g   = (r0_valid && r1_valid) ? !m_last : r1_valid;
      chk("r0_ready", r0_ready, acc && gv && !g);
      chk("r1_ready", r1_ready, acc && gv && g);
      xf = acc && gv;
      if (rst) begin
        sb.delete();
        m_valid = 0; m_bits = '0; m_src = 0; m_last = 1;
        m_g0 = 0; m_g1 = 0;
      end else begin
        if (m_valid && o_ready) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("sb_data", {o_src, o_bits}, e);
          end
        end
        if (xf) begin
          b = g ? r1_bits : r0_bits;
          s = g ? r1_shift : r0_shift;
          d = g ? r1_dir : r0_dir;
          res = d ? (b >> s) : (b << s);
          sb.push_back({g, res});
          m_valid = 1; m_bits = res; m_src = g; m_last = g;
          if (g) begin if (m_g1 < 65535) m_g1++; end
          else   begin if (m_g0 < 65535) m_g0++; end
        end else if (o_ready) m_valid = 0;
      end
    end
  end

  task automatic drive0(input logic v, input logic [W-1:0] b, input logic [SW-1:0] s, input logic d);
    r0_valid = v; r0_bits = b; r0_shift = s; r0_dir = d;
  endtask

  task automatic drive1(input logic v, input logic [W-1:0] b, input logic [SW-1:0] s, input logic d);
    r1_valid = v; r1_bits = b; r1_shift = s; r1_dir = d;
  endtask

  initial begin
    // 1: reset with r0 requesting; accept stays high but nothing transfers
    rst = 1; drive0(1, 8'h5A, 3'd2, 0);
    step();
    mon_en = 1;
    step();
    chk("t1_o_valid", o_valid, 0);
    chk("t1_o_bits", o_bits, 0);
    chk("t1_r0_ready", r0_ready, 1);

    // 2: lone requester, both directions
    rst = 0; o_ready = 1; drive0(1, 8'h81, 3'd1, 0);
    step();
    chk("t2_valid", o_valid, 1);
    chk("t2_left", o_bits, 8'h02);
    chk("t2_src", o_src, 0);
    drive0(1, 8'h80, 3'd7, 1);
    step();
    chk("t2_right", o_bits, 8'h01);
    drive0(1, 8'hFF, 3'd7, 0);
    step();
    chk("t2_left7", o_bits, 8'h80);
    drive0(0, 0, 0, 0);
    step();
    chk("t2_drain", o_valid, 0);

    // 3: contention after reset alternates starting with r0
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 6; i++) begin
      drive0(1, 8'h11 * i[7:0], i[2:0], i[0]);
      drive1(1, 8'hF0 ^ i[7:0], 3'(i + 1), !i[0]);
      step();
      chk("t3_src", o_src, i[0]);
      chk("t3_valid", o_valid, 1);
    end
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    step();

    // 4: backpressure holds the result; release transfers pending grant on same edge
    o_ready = 0; drive0(1, 8'h01, 3'd4, 0);
    step();
    chk("t4_load", o_bits, 8'h10);
    drive0(1, 8'h33, 3'd1, 0); drive1(1, 8'hC3, 3'd2, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_r0_ready", r0_ready, 0);
      chk("t4_r1_ready", r1_ready, 0);
      chk("t4_hold", o_bits, 8'h10);
    end
    o_ready = 1; #1;
    chk("t4_r1_gnt", r1_ready, 1);
    step();
    chk("t4_src", o_src, 1);
    chk("t4_bits", o_bits, 8'h30);
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    step();

    // 5: zero shift passes through; reset discards a held result
    drive0(1, 8'hA5, 3'd0, 0); step(); chk("t5_pass_l", o_bits, 8'hA5);
    drive0(1, 8'hA5, 3'd0, 1); step(); chk("t5_pass_r", o_bits, 8'hA5);
    o_ready = 0; drive0(1, 8'h3C, 3'd2, 1); step();
    chk("t5_full", o_valid, 1);
    drive0(0, 0, 0, 0); rst = 1; step(); rst = 0;
    chk("t5_rst_valid", o_valid, 0);
    chk("t5_rst_bits", o_bits, 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      drive0($urandom_range(0, 1) == 1, W'($urandom), SW'($urandom), $urandom_range(0, 1) == 1);
      drive1($urandom_range(0, 2) != 0, W'($urandom), SW'($urandom), $urandom_range(0, 1) == 1);
      o_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0); o_ready = 1;
    step(2);
    chk("rand_drained", sb.size(), 0);

`ifdef LR_SHIFT_ARB_STATS_EN
    // 6: counter saturation and clear
    rst = 1; step(); rst = 0;
    drive1(1, 8'h01, 3'd1, 0);
    step(70000);
    drive1(0, 0, 0, 0);
    step();
    chk("t6_g1_sat", g1_cnt, 16'hFFFF);
    chk("t6_g0", g0_cnt, 0);
    chk("t6_g1_model", g1_cnt, m_g1);
    rst = 1; step(); rst = 0;
    chk("t6_g0_clr", g0_cnt, 0);
    chk("t6_g1_clr", g1_cnt, 0);
`endif

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
